uart_8250_rx: RTL and testbench
===============================

UART_8250_RX -- requirements
Module: uart_8250_rx

Interface
REQ-001 Parameter OVERSAMPLE, default 16, meaning sample ticks per bit period; must be even and at least 4.
REQ-002 CLK_I  input  1  system clock; all state changes on its rising edge.
REQ-003 RST_I  input  1  asynchronous, active-low reset.
REQ-004 RX_I  input  1  serial line, asynchronous to CLK_I, idle high.
REQ-005 divisor_i  input  16  sample-tick divisor (8250 DLL/DLM value).
REQ-006 lcr_i  input  8  line control: [1:0] word length 5..8 bits, [3] parity enable, [4] even parity, [5] stick parity.
REQ-007 rx_data_o  output  8  received character, right-aligned, unused MSBs zero.
REQ-008 rx_valid_o  output  1  rx_data_o and the error flags hold a character.
REQ-009 rx_ready_i  input  1  consumer (RX FIFO) accepts the character.
REQ-010 frame_err_o, parity_err_o, break_o  output  1 each  error flags qualified by rx_valid_o.
REQ-011 overrun_o  output  1  one-cycle pulse when a character is dropped.
REQ-012 busy_o  output  1  high in any state other than IDLE.

Function
REQ-013 RX_I passes through a 2-flop synchronizer (rx_s); both flops reset to 1; no logic reads RX_I directly.
REQ-014 Sample tick: a one-cycle pulse every D CLK_I cycles, D = divisor_i, with 0 treated as 1; the divider counter clears on leaving IDLE.
REQ-015 FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-016 IDLE -> START on the first cycle rx_s is 0 (cycle 0).
REQ-017 START: at tick OVERSAMPLE/2 (cycle 8D for default), rx_s=1 -> IDLE (false start, no output); rx_s=0 -> DATA.
REQ-018 DATA: sample every OVERSAMPLE ticks, LSB first, count 5/6/7/8 bits per lcr_i[1:0]; after the last bit, go to PARITY if lcr_i[3] is set, else STOP.
REQ-019 PARITY: one sample; expected bit = odd parity if [4]=0, even parity if [4]=1; with [5]=1 the expected bit is ~lcr_i[4]; a mismatch sets parity_err.
REQ-020 STOP: a single sample at mid-bit; rx_s=0 sets frame_err; break = every data bit, the parity bit if enabled, and the stop bit all 0; then IDLE, so the next start edge is detectable from the following cycle.
REQ-021 lcr_i and divisor_i are captured at IDLE->START and held for the whole character.
REQ-022 Delivery at the STOP sample: if rx_valid_o is 0, or rx_valid_o and rx_ready_i are both 1 in that cycle, the output register loads and rx_valid_o is 1 from the next cycle.
REQ-023 Overrun: if rx_valid_o=1 and rx_ready_i=0 at delivery, the new character is dropped, overrun_o pulses for exactly 1 cycle, and the held output is unchanged.
REQ-024 Handshake: rx_valid_o falls the cycle after rx_valid_o and rx_ready_i are both high, unless REQ-022 reloads it; outputs are stable while valid and not ready.
REQ-025 Latency, 8N1, from cycle 0: rx_valid_o rises at cycle 8D + 16D*9 + 1 (D=1: 153); RX_I falling edge to cycle 0 is 2 cycles.
REQ-026 Error flags are per character, registered together with rx_data_o; none of them is sticky.

Reset
REQ-027 Reset state: FSM IDLE, counters 0, synchronizer 1, rx_data_o 0x00, all flags and rx_valid_o 0, busy_o 0.
REQ-028 Reset mid-character aborts it and produces no output; after release, a character starts only on a new falling edge of rx_s.

Verification
REQ-029 divisor_i=1, lcr_i=0x03, send 0x55 8N1 -> rx_data_o=0x55, rx_valid_o rises 155 cycles after the RX_I falling edge, no error flags.
REQ-030 divisor_i=3, lcr_i=0x1B (8E1), send 0xA7 with wrong parity bit 0 -> rx_data_o=0xA7, parity_err_o=1, frame_err_o=0.
REQ-031 lcr_i=0x00 (5N1), send 0x1F -> rx_data_o=0x1F; a 4-clock low glitch on an idle line -> no rx_valid_o, busy_o returns to 0.
REQ-032 Hold RX_I low for 20 bit times -> rx_data_o=0x00, frame_err_o=1, break_o=1; no second character until RX_I returns high and falls again.
REQ-033 rx_ready_i=0, send 0x11 then 0x22 -> rx_data_o stays 0x11, one overrun_o pulse; with rx_ready_i=1, back-to-back 0x33 and 0x44 with 1 stop bit -> both delivered.
REQ-034 Assert RST_I low during DATA of 0x5A -> all outputs at reset values immediately; the next full 0x66 frame is received correctly.

Source files
------------

// File: rtl/uart_8250_rx_if.sv
// rtl/uart_8250_rx_if.sv - received-character handshake between the UART receiver and its consumer
//
// Purpose: bundles the character output register, its error flags, the
// valid/ready handshake and the overrun pulse.
// Ports (signals):
//   rx_data_o    8  received character, right-aligned, unused MSBs zero
//   rx_valid_o   1  rx_data_o and the error flags hold a character
//   rx_ready_i   1  consumer accepts the character
//   frame_err_o  1  stop bit sampled low
//   parity_err_o 1  parity bit mismatch
//   break_o      1  whole frame (data, parity, stop) sampled low
//   overrun_o    1  one-cycle pulse when a character is dropped
// Modports: master = receiver side, slave = consumer side.

interface uart_8250_rx_if;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i;
  logic       frame_err_o;
  logic       parity_err_o;
  logic       break_o;
  logic       overrun_o;

  modport master (
    output rx_data_o, rx_valid_o, frame_err_o, parity_err_o, break_o, overrun_o,
    input  rx_ready_i
  );

  modport slave (
    input  rx_data_o, rx_valid_o, frame_err_o, parity_err_o, break_o, overrun_o,
    output rx_ready_i
  );
endinterface

// File: rtl/uart_8250_rx.sv
// rtl/uart_8250_rx.sv - 8250-style UART receiver with oversampled start/data/parity/stop sampling
//
// Purpose: synchronizes the serial line, detects a start bit, samples each
// bit at mid-period using a divided sample tick, checks parity and stop,
// and hands the character to a consumer over a valid/ready handshake.
// Ports:
//   CLK_I      in   1  system clock
//   RST_I      in   1  asynchronous active-low reset
//   RX_I       in   1  serial line, idle high, asynchronous to CLK_I
//   divisor_i  in  16  sample-tick divisor (0 behaves as 1)
//   lcr_i      in   8  [1:0] word length 5..8, [3] parity en, [4] even, [5] stick
//   busy_o     out  1  receiver is not idle
//   rx_if      master modport: character, flags, valid/ready, overrun

module uart_8250_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        RX_I,
  input  logic [15:0] divisor_i,
  input  logic [7:0]  lcr_i,
  output logic        busy_o,
  uart_8250_rx_if.master rx_if
);

  if ((OVERSAMPLE < 4) || ((OVERSAMPLE % 2) != 0)) begin : g_bad_oversample
    $error("OVERSAMPLE must be even and at least 4");
  end

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  // Line synchronizer
  logic rx_meta;
  logic rx_s;

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RX_I;
      rx_s    <= rx_meta;
    end
  end

  state_t        state;
  logic [15:0]   div_q;
  logic [15:0]   div_cnt;
  logic [TW-1:0] tick_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [1:0]    wlen_q;
  logic          pen_q;
  logic          eps_q;
  logic          stick_q;
  logic          par_q;
  logic          par_err_q;
  // Cleared after a frame whose stop bit was low (break / held-low line);
  // the line must be seen high again before a new start is accepted.
  logic          armed;

  logic          tick;
  logic          sample_pt;
  logic          sample;
  logic [2:0]    last_bit;
  logic [7:0]    data_al;
  logic          par_exp;
  logic          brk_now;

  logic unused_lcr;
  assign unused_lcr = ^{lcr_i[7:6], lcr_i[2]};

  assign busy_o    = (state != ST_IDLE);
  assign tick      = (state != ST_IDLE) && (div_cnt == div_q - 16'd1);
  // The start bit is confirmed half a bit in; every later bit a full bit on.
  assign sample_pt = (state == ST_START) ? (tick_cnt == HALF_M1) : (tick_cnt == FULL_M1);
  assign sample    = tick && sample_pt;
  // Index of the last data bit is word length - 1 = 4 + lcr[1:0].
  assign last_bit  = {1'b1, wlen_q};

  // Bits enter at the MSB, so a short word ends up left-aligned in shreg.
  always_comb begin
    data_al = shreg;
    case (wlen_q)
      2'd0:    data_al = {3'b000, shreg[7:3]};
      2'd1:    data_al = {2'b00,  shreg[7:2]};
      2'd2:    data_al = {1'b0,   shreg[7:1]};
      default: data_al = shreg;
    endcase
  end

  assign par_exp = stick_q ? ~eps_q : (eps_q ? ^data_al : ~^data_al);
  assign brk_now = (data_al == 8'h00) && (!pen_q || !par_q) && !rx_s;

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state              <= ST_IDLE;
      div_q              <= 16'd1;
      div_cnt            <= 16'd0;
      tick_cnt           <= '0;
      bit_cnt            <= 3'd0;
      shreg              <= 8'h00;
      wlen_q             <= 2'd0;
      pen_q              <= 1'b0;
      eps_q              <= 1'b0;
      stick_q            <= 1'b0;
      par_q              <= 1'b0;
      par_err_q          <= 1'b0;
      armed              <= 1'b0;
      rx_if.rx_data_o    <= 8'h00;
      rx_if.rx_valid_o   <= 1'b0;
      rx_if.frame_err_o  <= 1'b0;
      rx_if.parity_err_o <= 1'b0;
      rx_if.break_o      <= 1'b0;
      rx_if.overrun_o    <= 1'b0;
    end else begin
      rx_if.overrun_o <= 1'b0;
      if (rx_if.rx_valid_o && rx_if.rx_ready_i) begin
        rx_if.rx_valid_o <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          div_cnt  <= 16'd0;
          tick_cnt <= '0;
          bit_cnt  <= 3'd0;
          if (rx_s) begin
            armed <= 1'b1;
          end else if (armed) begin
            state     <= ST_START;
            div_q     <= (divisor_i == 16'd0) ? 16'd1 : divisor_i;
            wlen_q    <= lcr_i[1:0];
            pen_q     <= lcr_i[3];
            eps_q     <= lcr_i[4];
            stick_q   <= lcr_i[5];
            par_q     <= 1'b0;
            par_err_q <= 1'b0;
          end
        end

        default: begin
          if (tick) begin
            div_cnt  <= 16'd0;
            tick_cnt <= sample_pt ? '0 : tick_cnt + TW'(1);
          end else begin
            div_cnt  <= div_cnt + 16'd1;
          end

          if (sample) begin
            case (state)
              ST_START: begin
                state <= rx_s ? ST_IDLE : ST_DATA;
              end
              ST_DATA: begin
                shreg   <= {rx_s, shreg[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == last_bit) begin
                  state <= pen_q ? ST_PARITY : ST_STOP;
                end
              end
              ST_PARITY: begin
                par_q     <= rx_s;
                par_err_q <= (rx_s != par_exp);
                state     <= ST_STOP;
              end
              ST_STOP: begin
                state <= ST_IDLE;
                if (!rx_s) begin
                  armed <= 1'b0;
                end
                if (!rx_if.rx_valid_o || rx_if.rx_ready_i) begin
                  rx_if.rx_data_o    <= data_al;
                  rx_if.rx_valid_o   <= 1'b1;
                  rx_if.frame_err_o  <= !rx_s;
                  rx_if.parity_err_o <= pen_q && par_err_q;
                  rx_if.break_o      <= brk_now;
                end else begin
                  rx_if.overrun_o <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_8250_rx.sv
// tb/tb_uart_8250_rx.sv - self-checking bench for uart_8250_rx

module tb_uart_8250_rx;
  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b0;
  logic        RX_I  = 1'b1;
  logic [15:0] divisor_i = 16'd1;
  logic [7:0]  lcr_i = 8'h03;
  logic        busy_o;

  uart_8250_rx_if rx_if();

  uart_8250_rx #(.OVERSAMPLE(16)) dut (
    .CLK_I     (CLK_I),
    .RST_I     (RST_I),
    .RX_I      (RX_I),
    .divisor_i (divisor_i),
    .lcr_i     (lcr_i),
    .busy_o    (busy_o),
    .rx_if     (rx_if)
  );

  always #5 CLK_I = ~CLK_I;

  int cyc = 0;
  always @(posedge CLK_I) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Expected characters, each with the cycle at which it must appear.
  typedef struct {
    int         upd;
    logic [7:0] data;
    logic       pe;
    logic       fe;
    logic       brk;
  } exp_t;
  exp_t pq[$];

  logic [7:0] m_data  = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_pe    = 1'b0;
  logic       m_fe    = 1'b0;
  logic       m_brk   = 1'b0;
  logic       m_ovr   = 1'b0;

  always @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      m_data  <= 8'h00;
      m_valid <= 1'b0;
      m_pe    <= 1'b0;
      m_fe    <= 1'b0;
      m_brk   <= 1'b0;
      m_ovr   <= 1'b0;
      pq.delete();
    end else begin
      m_ovr <= 1'b0;
      if (pq.size() > 0 && pq[0].upd == cyc + 1) begin
        if (!m_valid || rx_if.rx_ready_i) begin
          m_data  <= pq[0].data;
          m_pe    <= pq[0].pe;
          m_fe    <= pq[0].fe;
          m_brk   <= pq[0].brk;
          m_valid <= 1'b1;
        end else begin
          m_ovr <= 1'b1;
        end
        pq.pop_front();
      end else if (m_valid && rx_if.rx_ready_i) begin
        m_valid <= 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge CLK_I) begin
    check("valid", rx_if.rx_valid_o, m_valid);
    check("overrun", rx_if.overrun_o, m_ovr);
    if (m_valid) begin
      check("data", rx_if.rx_data_o, m_data);
      check("parity_err", rx_if.parity_err_o, m_pe);
      check("frame_err", rx_if.frame_err_o, m_fe);
      check("break", rx_if.break_o, m_brk);
    end
  end

  // Observation helpers for the hand-computed checks.
  logic       prev_valid = 1'b0;
  int         last_rise  = 0;
  int         rise_count = 0;
  int         ovr_count  = 0;
  logic [7:0] cap_data   = 8'h00;
  logic       cap_pe = 1'b0, cap_fe = 1'b0, cap_brk = 1'b0;
  logic [7:0] acc_q[$];

  always @(negedge CLK_I) begin
    prev_valid <= rx_if.rx_valid_o;
    if (rx_if.rx_valid_o && !prev_valid) begin
      last_rise  <= cyc;
      rise_count <= rise_count + 1;
      cap_data   <= rx_if.rx_data_o;
      cap_pe     <= rx_if.parity_err_o;
      cap_fe     <= rx_if.frame_err_o;
      cap_brk    <= rx_if.break_o;
    end
    if (rx_if.overrun_o) ovr_count <= ovr_count + 1;
    if (rx_if.rx_valid_o && rx_if.rx_ready_i) acc_q.push_back(rx_if.rx_data_o);
  end

  int last_fall = 0;

  task automatic send_frame(input logic [7:0] d, input int nb, input bit pen,
                            input bit pbit, input bit stopv);
    int         dd;
    int         b;
    exp_t       e;
    logic [7:0] dm;
    logic       pexp;
    dd = (divisor_i == 16'd0) ? 1 : int'(divisor_i);
    b  = 16 * dd;
    dm = 8'((32'(d)) & ((32'd1 << nb) - 32'd1));
    if (lcr_i[5])      pexp = ~lcr_i[4];
    else if (lcr_i[4]) pexp = ^dm;
    else               pexp = ~^dm;
    @(posedge CLK_I); #1;
    RX_I      = 1'b0;
    last_fall = cyc;
    e.upd  = cyc + 3 + 8 * dd + b * (nb + int'(pen) + 1);
    e.data = dm;
    e.pe   = pen && (pbit != pexp);
    e.fe   = !stopv;
    e.brk  = (dm == 8'h00) && (!pen || !pbit) && !stopv;
    pq.push_back(e);
    repeat (b) @(posedge CLK_I); #1;
    for (int i = 0; i < nb; i++) begin
      RX_I = d[i];
      repeat (b) @(posedge CLK_I); #1;
    end
    if (pen) begin
      RX_I = pbit;
      repeat (b) @(posedge CLK_I); #1;
    end
    RX_I = stopv;
    repeat (b) @(posedge CLK_I); #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge CLK_I);
    #1;
  endtask

  int rc0;
  int oc0;

  initial begin
    rx_if.rx_ready_i = 1'b1;

    // Reset state
    repeat (3) @(negedge CLK_I);
    check("rst valid", rx_if.rx_valid_o, 1'b0);
    check("rst data", rx_if.rx_data_o, 8'h00);
    check("rst busy", busy_o, 1'b0);
    check("rst flags", {rx_if.frame_err_o, rx_if.parity_err_o, rx_if.break_o, rx_if.overrun_o}, 4'b0000);
    @(posedge CLK_I); #1;
    RST_I = 1'b1;
    idle_cycles(5);

    // 8N1, D=1, 0x55: valid at fall + 8 + 144 + 3 = 155
    divisor_i = 16'd1; lcr_i = 8'h03;
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1);
    check("8N1 latency", last_rise - last_fall, 155);
    check("8N1 data", cap_data, 8'h55);
    check("8N1 flags", {cap_pe, cap_fe, cap_brk}, 3'b000);
    idle_cycles(20);

    // 8E1, D=3, 0xA7 (five ones -> even parity bit 1) sent with parity 0
    divisor_i = 16'd3; lcr_i = 8'h1B;
    send_frame(8'hA7, 8, 1'b1, 1'b0, 1'b1);
    check("8E1 latency", last_rise - last_fall, 507);
    check("8E1 data", cap_data, 8'hA7);
    check("8E1 parity_err", cap_pe, 1'b1);
    check("8E1 frame_err", cap_fe, 1'b0);
    idle_cycles(20);

    // 5N1, D=2, 0x1F
    divisor_i = 16'd2; lcr_i = 8'h00;
    send_frame(8'h1F, 5, 1'b0, 1'b0, 1'b1);
    check("5N1 latency", last_rise - last_fall, 211);
    check("5N1 data", cap_data, 8'h1F);
    idle_cycles(20);

    // 4-clock glitch on the idle line: false start, no character
    rc0 = rise_count;
    RX_I = 1'b0;
    idle_cycles(4);
    RX_I = 1'b1;
    idle_cycles(6);
    check("glitch busy", busy_o, 1'b1);
    idle_cycles(30);
    check("glitch idle", busy_o, 1'b0);
    check("glitch no char", rise_count - rc0, 0);

    // Break: line held low for 20 bit times
    divisor_i = 16'd1; lcr_i = 8'h03;
    send_frame(8'h00, 8, 1'b0, 1'b0, 1'b0);
    rc0 = rise_count;
    idle_cycles(16 * 10);
    check("break data", cap_data, 8'h00);
    check("break frame_err", cap_fe, 1'b1);
    check("break flag", cap_brk, 1'b1);
    check("break single char", rise_count - rc0, 0);
    RX_I = 1'b1;
    idle_cycles(32);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1);
    check("after break data", cap_data, 8'h3C);
    check("after break flags", {cap_fe, cap_brk}, 2'b00);
    idle_cycles(20);

    // Overrun with consumer stalled
    rx_if.rx_ready_i = 1'b0;
    oc0 = ovr_count;
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1);
    @(negedge CLK_I);
    check("overrun held data", rx_if.rx_data_o, 8'h11);
    check("overrun held valid", rx_if.rx_valid_o, 1'b1);
    check("overrun pulses", ovr_count - oc0, 1);
    @(posedge CLK_I); #1;
    rx_if.rx_ready_i = 1'b1;
    idle_cycles(3);
    check("drained", rx_if.rx_valid_o, 1'b0);

    // Back-to-back with one stop bit
    rc0 = rise_count;
    send_frame(8'h33, 8, 1'b0, 1'b0, 1'b1);
    send_frame(8'h44, 8, 1'b0, 1'b0, 1'b1);
    idle_cycles(5);
    check("b2b count", rise_count - rc0, 2);
    check("b2b first", acc_q[acc_q.size() - 2], 8'h33);
    check("b2b second", acc_q[acc_q.size() - 1], 8'h44);

    // Reset during the data bits of 0x5A
    rc0 = rise_count;
    RX_I = 1'b0;        // start
    idle_cycles(16);
    RX_I = 1'b0;        // bit0
    idle_cycles(16);
    RX_I = 1'b1;        // bit1
    idle_cycles(8);
    check("pre-reset busy", busy_o, 1'b1);
    RST_I = 1'b0;
    #1;
    check("mid reset busy", busy_o, 1'b0);
    check("mid reset valid", rx_if.rx_valid_o, 1'b0);
    check("mid reset data", rx_if.rx_data_o, 8'h00);
    idle_cycles(3);
    RX_I = 1'b1;
    idle_cycles(2);
    RST_I = 1'b1;
    idle_cycles(32);
    check("aborted no char", rise_count - rc0, 0);
    send_frame(8'h66, 8, 1'b0, 1'b0, 1'b1);
    check("post reset data", cap_data, 8'h66);
    check("post reset flags", {cap_pe, cap_fe, cap_brk}, 3'b000);
    idle_cycles(20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
